simd_mul_collector: RTL and testbench

- Downstream stage of the vector-lane SIMD multiplier.
- The multiplier has a fixed one-register latency and no valid or stall. This block aligns per-issue metadata with the multiplier result and optionally performs SEW-aware multiply-accumulate (vmacc / vnmsac style).
- Results are buffered in a small FIFO and presented to lane writeback over a valid/ready handshake.
- Issue credit guarantees the multiplier output is never dropped.

---
 rtl/simd_mul_collector_pkg.sv | 17 +
 rtl/simd_acc_adder.sv | 47 ++++
 rtl/simd_mul_collector.sv | 157 +++++++++++++++
 tb/tb_simd_mul_collector.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_mul_collector_pkg.sv
// Shared vector-lane definitions: SEW encodings and the writeback collector entry.
package simd_mul_collector_pkg;

    localparam int unsigned SEW_8  = 0;
    localparam int unsigned SEW_16 = 1;
    localparam int unsigned SEW_32 = 2;
    localparam int unsigned SEW_64 = 3;

    localparam int unsigned CollTagW  = 8;
    localparam int unsigned CollDataW = 64;

    typedef struct packed {
        logic [CollTagW-1:0]  tag;
        logic [CollDataW-1:0] data;
    } coll_entry_t;

endpackage

// File: rtl/simd_acc_adder.sv
// SEW-segmented adder/subtractor: a + b or a - b per element, no carry across elements.
module simd_acc_adder #(
    parameter int unsigned MIN_WIDTH = 8,
    parameter int unsigned MAX_WIDTH = 64,
    parameter int unsigned SEW_WIDTH = $clog2(MAX_WIDTH / MIN_WIDTH) + 1
) (
    input  logic [SEW_WIDTH-1:0] sew_i,
    input  logic                 sub_i,
    input  logic [MAX_WIDTH-1:0] a_i,
    input  logic [MAX_WIDTH-1:0] b_i,
    output logic [MAX_WIDTH-1:0] sum_o
);

    localparam int unsigned MaxSew = $clog2(MAX_WIDTH / MIN_WIDTH);

    int unsigned          sew_eff;
    logic [MAX_WIDTH-1:0] seg_start;

    // seg_start marks the LSB of every element; it kills the incoming carry there.
    always_comb begin
        sew_eff   = (32'(sew_i) > MaxSew) ? MaxSew : 32'(sew_i);
        seg_start = '0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            for (int unsigned s = 0; s <= MaxSew; s++) begin
                if ((sew_eff == s) && ((i % (MIN_WIDTH << s)) == 0)) begin
                    seg_start[i] = 1'b1;
                end
            end
        end
    end

    // Subtraction is a + ~b + 1, with the +1 injected at each element start.
    always_comb begin
        logic carry;
        logic cin;
        logic bb;
        sum_o = '0;
        carry = 1'b0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            cin      = seg_start[i] ? sub_i : carry;
            bb       = b_i[i] ^ sub_i;
            sum_o[i] = a_i[i] ^ bb ^ cin;
            carry    = (a_i[i] & bb) | (cin & (a_i[i] ^ bb));
        end
    end

endmodule

// File: rtl/simd_mul_collector.sv
// Aligns issue metadata with the fixed-latency multiplier result, optionally accumulates,
// and queues results for lane writeback under issue credit.
module simd_mul_collector
    import simd_mul_collector_pkg::*;
#(
    parameter int unsigned MIN_WIDTH = 8,
    parameter int unsigned MAX_WIDTH = CollDataW,
    parameter int unsigned SEW_WIDTH = $clog2(MAX_WIDTH / MIN_WIDTH) + 1,
    parameter int unsigned MUL_LAT   = 1,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TAG_W     = CollTagW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 issue_valid_i,
    output logic                 issue_ready_o,
    input  logic [TAG_W-1:0]     issue_tag_i,
    input  logic [SEW_WIDTH-1:0] issue_sew_i,
    input  logic                 issue_acc_i,
    input  logic                 issue_sub_i,
    input  logic [MAX_WIDTH-1:0] issue_accop_i,
    input  logic [MAX_WIDTH-1:0] mul_result_i,
    output logic                 wb_valid_o,
    input  logic                 wb_ready_i,
    output logic [TAG_W-1:0]     wb_tag_o,
    output logic [MAX_WIDTH-1:0] wb_data_o
);

    localparam int unsigned Fin  = MUL_LAT - 1;
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic                 dl_valid_q [MUL_LAT];
    logic [TAG_W-1:0]     dl_tag_q   [MUL_LAT];
    logic [SEW_WIDTH-1:0] dl_sew_q   [MUL_LAT];
    logic                 dl_acc_q   [MUL_LAT];
    logic                 dl_sub_q   [MUL_LAT];
    logic [MAX_WIDTH-1:0] dl_accop_q [MUL_LAT];

    coll_entry_t          mem_q [DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;

    logic                 issue_fire, push, pop;
    logic [MAX_WIDTH-1:0] acc_sum, fin_data;
    int unsigned          inflight;

    assign issue_fire = issue_valid_i && issue_ready_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < MUL_LAT; k++) begin
                dl_valid_q[k] <= 1'b0;
                dl_tag_q[k]   <= '0;
                dl_sew_q[k]   <= '0;
                dl_acc_q[k]   <= 1'b0;
                dl_sub_q[k]   <= 1'b0;
                dl_accop_q[k] <= '0;
            end
        end else begin
            dl_valid_q[0] <= issue_fire && !flush_i;
            if (issue_fire) begin
                dl_tag_q[0]   <= issue_tag_i;
                dl_sew_q[0]   <= issue_sew_i;
                dl_acc_q[0]   <= issue_acc_i;
                dl_sub_q[0]   <= issue_sub_i;
                dl_accop_q[0] <= issue_accop_i;
            end
            for (int unsigned k = 1; k < MUL_LAT; k++) begin
                dl_valid_q[k] <= dl_valid_q[k-1] && !flush_i;
                dl_tag_q[k]   <= dl_tag_q[k-1];
                dl_sew_q[k]   <= dl_sew_q[k-1];
                dl_acc_q[k]   <= dl_acc_q[k-1];
                dl_sub_q[k]   <= dl_sub_q[k-1];
                dl_accop_q[k] <= dl_accop_q[k-1];
            end
        end
    end

    simd_acc_adder #(
        .MIN_WIDTH (MIN_WIDTH),
        .MAX_WIDTH (MAX_WIDTH),
        .SEW_WIDTH (SEW_WIDTH)
    ) u_acc_adder (
        .sew_i (dl_sew_q[Fin]),
        .sub_i (dl_sub_q[Fin]),
        .a_i   (dl_accop_q[Fin]),
        .b_i   (mul_result_i),
        .sum_o (acc_sum)
    );

    assign fin_data = dl_acc_q[Fin] ? acc_sum : mul_result_i;
    assign push     = dl_valid_q[Fin];
    assign pop      = wb_valid_o && wb_ready_i;

    always_comb begin
        inflight = 0;
        for (int unsigned k = 0; k < MUL_LAT; k++) begin
            if (dl_valid_q[k]) begin
                inflight = inflight + 1;
            end
        end
    end

    // Credit counts queued entries plus results still in the multiplier.
    assign issue_ready_o = (32'(count_q) + inflight) < DEPTH;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push && !flush_i) begin
                mem_q[wr_ptr_q] <= '{tag: dl_tag_q[Fin], data: fin_data};
            end
        end
    end

    assign wb_valid_o = (count_q != '0);
    assign wb_tag_o   = mem_q[rd_ptr_q].tag;
    assign wb_data_o  = mem_q[rd_ptr_q].data;

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        push |-> (count_q != CntW'(DEPTH)));

endmodule

// File: tb/tb_simd_mul_collector.sv
// Scoreboard bench for simd_mul_collector: expected entries queued at issue, compared on pop.
module tb_simd_mul_collector;
    import simd_mul_collector_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [7:0]  issue_tag_i;
    logic [3:0]  issue_sew_i;
    logic        issue_acc_i;
    logic        issue_sub_i;
    logic [63:0] issue_accop_i;
    logic [63:0] mul_result_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [7:0]  wb_tag_o;
    logic [63:0] wb_data_o;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;
    logic [63:0] pend_prod = '0;
    logic [71:0] exp_q[$];
    logic [71:0] obs_q[$];

    always #5 clk = ~clk;

    simd_mul_collector u_dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .issue_valid_i (issue_valid_i),
        .issue_ready_o (issue_ready_o),
        .issue_tag_i   (issue_tag_i),
        .issue_sew_i   (issue_sew_i),
        .issue_acc_i   (issue_acc_i),
        .issue_sub_i   (issue_sub_i),
        .issue_accop_i (issue_accop_i),
        .mul_result_i  (mul_result_i),
        .wb_valid_o    (wb_valid_o),
        .wb_ready_i    (wb_ready_i),
        .wb_tag_o      (wb_tag_o),
        .wb_data_o     (wb_data_o)
    );

    // Element-wise arithmetic model, independent of any carry-chain structure.
    function automatic logic [63:0] model(input logic [3:0] sew, input logic acc,
                                          input logic sub, input logic [63:0] a,
                                          input logic [63:0] b);
        int unsigned w;
        logic [63:0] r, x, y, z, mask;
        if (!acc) return b;
        w    = (sew > 4'd3) ? 64 : (8 << sew);
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        r    = '0;
        for (int e = 0; e < 64 / int'(w); e++) begin
            x = a >> (e * int'(w));
            y = b >> (e * int'(w));
            z = sub ? (x - y) : (x + y);
            r = r | ((z & mask) << (e * int'(w)));
        end
        return r;
    endfunction

    // One clock: apply inputs, log accept/pop into the scoreboard, advance to edge+1.
    task automatic step(input logic v, input logic [7:0] tag, input logic [3:0] sew,
                        input logic acc, input logic sub, input logic [63:0] accop,
                        input logic [63:0] prod, input logic rdy, input logic fl);
        issue_valid_i = v;
        issue_tag_i   = tag;
        issue_sew_i   = sew;
        issue_acc_i   = acc;
        issue_sub_i   = sub;
        issue_accop_i = accop;
        mul_result_i  = pend_prod;
        wb_ready_i    = rdy;
        flush_i       = fl;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (wb_valid_o && rdy) obs_q.push_back({wb_tag_o, wb_data_o});
            if (v && issue_ready_o) begin
                exp_q.push_back({tag, model(sew, acc, sub, accop, prod)});
                n_acc++;
            end
        end
        @(posedge clk);
        #1;
        pend_prod = prod;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 64'h0, 64'h0, rdy, 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(1'b0);
        idle(1'b0);
        n_tests++;
        if (wb_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid_o);
        end
        n_tests++;
        if (issue_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_issue_ready got=%b exp=1", issue_ready_o);
        end
        n_tests++;
        if (wb_tag_o !== 8'h00) begin
            n_fail++; $display("FAIL reset_wb_tag got=%h exp=00", wb_tag_o);
        end
        n_tests++;
        if (wb_data_o !== 64'h0) begin
            n_fail++; $display("FAIL reset_wb_data got=%h exp=0", wb_data_o);
        end
        rst = 1'b0;
        idle(1'b0);
    endtask

    task automatic test_single;
        logic [71:0] e, o;
        step(1'b1, 8'h11, 4'd0, 1'b0, 1'b0, 64'h0, 64'h0F0F, 1'b0, 1'b0);
        n_tests++;
        if (wb_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL single_early_valid got=%b exp=0", wb_valid_o);
        end
        idle(1'b0);
        n_tests++;
        if (wb_valid_o !== 1'b1 || wb_tag_o !== 8'h11 || wb_data_o !== 64'h0F0F) begin
            n_fail++;
            $display("FAIL single_result got=%b/%h/%h exp=1/11/0000000000000f0f",
                     wb_valid_o, wb_tag_o, wb_data_o);
        end
        for (int i = 0; i < 3; i++) idle(1'b1);
        n_tests++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            n_fail++; $display("FAIL single_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++; $display("FAIL single_sb got=%h exp=%h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_accumulate;
        logic [71:0] e, o;
        logic [63:0] want [3];
        want[0] = 64'h0;
        want[1] = 64'h0101_0101_0101_0100;
        want[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        step(1'b1, 8'h20, 4'd0, 1'b1, 1'b0, '1, 64'h0101_0101_0101_0101, 1'b1, 1'b0);
        step(1'b1, 8'h21, 4'd3, 1'b1, 1'b0, '1, 64'h0101_0101_0101_0101, 1'b1, 1'b0);
        step(1'b1, 8'h22, 4'd1, 1'b1, 1'b1, 64'h0, 64'h0001_0001_0001_0001, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) idle(1'b1);
        n_tests++;
        if (obs_q.size() != 3) begin
            n_fail++; $display("FAIL acc_count got=%0d exp=3", obs_q.size());
        end
        for (int i = 0; i < 3 && obs_q.size() > 0; i++) begin
            o = obs_q.pop_front();
            n_tests++;
            if (o[63:0] !== want[i] || o[71:64] !== 8'(8'h20 + i)) begin
                n_fail++;
                $display("FAIL acc_vec%0d got=%h exp=%h%h", i, o, 8'(8'h20 + i), want[i]);
            end
        end
        exp_q.delete();
        // Random mix of sew (incl. out-of-range codes), add/sub and back-pressure.
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 4'($urandom_range(0, 7)),
                 1'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                 1'($urandom_range(0, 2) != 0), 1'b0);
        end
        for (int i = 0; i < 10; i++) idle(1'b1);
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rand_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++; $display("FAIL rand_sb got=%h exp=%h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_back_pressure;
        logic [71:0] o;
        int base;
        base = n_acc;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(n_acc - base), 4'd0, 1'b0, 1'b0, 64'h0, 64'(100 + i), 1'b0, 1'b0);
        end
        n_tests++;
        if (n_acc - base != 4) begin
            n_fail++; $display("FAIL bp_accepts got=%0d exp=4", n_acc - base);
        end
        n_tests++;
        if (issue_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_ready_low got=%b exp=0", issue_ready_o);
        end
        idle(1'b1);
        n_tests++;
        if (issue_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL bp_ready_return got=%b exp=1", issue_ready_o);
        end
        for (int i = 0; i < 5; i++) idle(1'b1);
        n_tests++;
        if (obs_q.size() != 4) begin
            n_fail++; $display("FAIL bp_pops got=%0d exp=4", obs_q.size());
        end
        for (int i = 0; i < 4 && obs_q.size() > 0; i++) begin
            o = obs_q.pop_front();
            n_tests++;
            if (o[71:64] !== 8'(i)) begin
                n_fail++; $display("FAIL bp_order got=%h exp=%h", o[71:64], 8'(i));
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_flush;
        logic [71:0] e, o;
        step(1'b1, 8'hA0, 4'd0, 1'b0, 1'b0, 64'h0, 64'hA0, 1'b0, 1'b0);
        step(1'b1, 8'hA1, 4'd0, 1'b0, 1'b0, 64'h0, 64'hA1, 1'b0, 1'b0);
        step(1'b1, 8'hA2, 4'd0, 1'b0, 1'b0, 64'h0, 64'hA2, 1'b0, 1'b0);
        // Issue in the flush cycle must be dropped as well.
        step(1'b1, 8'hEE, 4'd0, 1'b0, 1'b0, 64'h0, 64'hEE, 1'b1, 1'b1);
        n_tests++;
        if (wb_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_valid got=%b exp=0", wb_valid_o);
        end
        n_tests++;
        if (issue_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL flush_ready got=%b exp=1", issue_ready_o);
        end
        idle(1'b0);
        idle(1'b0);
        n_tests++;
        if (wb_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_late_write got=%b exp=0", wb_valid_o);
        end
        step(1'b1, 8'hB0, 4'd2, 1'b1, 1'b1, 64'h0000_0005_0000_0003,
             64'h0000_0006_0000_0001, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        n_tests++;
        if (obs_q.size() != 1) begin
            n_fail++; $display("FAIL flush_resume_count got=%0d exp=1", obs_q.size());
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e || o[63:0] !== 64'hFFFF_FFFF_0000_0002) begin
                n_fail++; $display("FAIL flush_resume got=%h exp=%h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_async_reset;
        logic [71:0] e, o;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'(8'hC0 + i), 4'd0, 1'b0, 1'b0, 64'h0, 64'(i), 1'b0, 1'b0);
        end
        idle(1'b0);
        n_tests++;
        if (wb_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL arst_prefill got=%b exp=1", wb_valid_o);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (wb_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL arst_valid got=%b exp=0", wb_valid_o);
        end
        n_tests++;
        if (issue_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL arst_ready got=%b exp=1", issue_ready_o);
        end
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
        pend_prod = '0;
        @(posedge clk);
        #1;
        step(1'b1, 8'h5A, 4'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0001,
             64'h0000_0001_FFFF_FFFF, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        n_tests++;
        if (obs_q.size() != 1) begin
            n_fail++; $display("FAIL arst_resume_count got=%0d exp=1", obs_q.size());
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e || o[63:0] !== 64'h0) begin
                n_fail++; $display("FAIL arst_resume got=%h exp=%h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        flush_i       = 1'b0;
        issue_valid_i = 1'b0;
        issue_tag_i   = '0;
        issue_sew_i   = 4'(SEW_8);
        issue_acc_i   = 1'b0;
        issue_sub_i   = 1'b0;
        issue_accop_i = '0;
        mul_result_i  = '0;
        wb_ready_i    = 1'b0;
        test_reset();
        test_single();
        test_accumulate();
        test_back_pressure();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
